// File: rtl/dcs_sel_ctrl.sv
// dcs_sel_ctrl: break-before-make select controller in front of a Gowin_DCS clock mux.
// It converts a requested source index into a one-hot clksel. Between sources it holds
// clksel all-zero for a gate window, then waits a settle window before signalling done.
// It also watches the synchronized per-source health and falls back to a safe source
// when the active one goes bad.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | clksel = onehot(cur_sel); accepts requests or starts fallback
// ST_OFF   | clksel = 0; gate window of OFF_CYCLES cycles
// ST_SETTLE| clksel = onehot(target); settle window of SETTLE_CYCLES cycles
module dcs_sel_ctrl #(
    parameter int unsigned OFF_CYCLES    = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned RESET_SEL     = 0,
    parameter int unsigned FALLBACK_SEL  = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    input  logic [1:0] i_req_sel,
    output logic       o_req_ready,
    input  logic [3:0] i_clk_ok,
    output logic [3:0] o_clksel,
    output logic [1:0] o_cur_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic       o_fallback
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFF    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [1:0] RESET_IDX   = 2'(RESET_SEL);
    localparam logic [1:0] FB_IDX      = 2'(FALLBACK_SEL);
    localparam logic [7:0] OFF_LOAD    = 8'(OFF_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    logic       r_rst_meta;
    logic       r_rst_sync;
    logic       w_rst_n;
    logic [3:0] r_ok_meta;
    logic [3:0] r_ok_sync;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] r_target;
    logic [1:0] w_target_nxt;
    logic [3:0] r_clksel;
    logic [3:0] w_clksel_nxt;
    logic [1:0] r_cur_sel;
    logic [1:0] w_cur_sel_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       r_fallback;
    logic       w_fallback_nxt;

    logic       w_fb_need;
    logic       w_accept;

    // Reset is asserted asynchronously but released only on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    // Two-flop synchronizer for the asynchronous per-source health flags.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ok_meta <= 4'b0000;
            r_ok_sync <= 4'b0000;
        end else begin
            r_ok_meta <= i_clk_ok;
            r_ok_sync <= r_ok_meta;
        end
    end

    // The fallback source is never itself a fallback trigger, so a dead fallback cannot loop.
    assign w_fb_need   = !r_ok_sync[r_cur_sel] && (r_cur_sel != FB_IDX);
    assign o_req_ready = (r_state == ST_IDLE) && !w_fb_need;
    assign w_accept    = i_req_valid && o_req_ready;

    // State and datapath registers; everything returns to the reset selection immediately.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_target   <= RESET_IDX;
            r_clksel   <= onehot(RESET_IDX);
            r_cur_sel  <= RESET_IDX;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_fallback <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_target   <= w_target_nxt;
            r_clksel   <= w_clksel_nxt;
            r_cur_sel  <= w_cur_sel_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_fallback <= w_fallback_nxt;
        end
    end

    // Next-state logic: fallback beats requests; the gate and settle windows are down-counters.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_target_nxt   = r_target;
        w_clksel_nxt   = r_clksel;
        w_cur_sel_nxt  = r_cur_sel;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_fallback_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fb_need) begin
                    w_target_nxt   = FB_IDX;
                    w_fallback_nxt = 1'b1;
                    w_state_nxt    = ST_OFF;
                    w_clksel_nxt   = 4'b0000;
                    w_cnt_nxt      = OFF_LOAD;
                end else if (w_accept) begin
                    if (i_req_sel == r_cur_sel) begin
                        w_done_nxt = 1'b1;
                    end else if (!r_ok_sync[i_req_sel]) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_target_nxt = i_req_sel;
                        w_state_nxt  = ST_OFF;
                        w_clksel_nxt = 4'b0000;
                        w_cnt_nxt    = OFF_LOAD;
                    end
                end
            end

            ST_OFF: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt   = ST_SETTLE;
                    w_clksel_nxt  = onehot(r_target);
                    w_cur_sel_nxt = r_target;
                    w_cnt_nxt     = SETTLE_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            ST_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_clksel   = r_clksel;
    assign o_cur_sel  = r_cur_sel;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_fallback = r_fallback;

endmodule

// File: tb/tb_dcs_sel_ctrl.sv
// Bench for dcs_sel_ctrl: table of switch requests plus hand sequences for fallback,
// fallback-vs-request priority, dead fallback source and reset during the gate window.
module tb_dcs_sel_ctrl;

    localparam int OFF = 8;
    localparam int SET = 16;
    localparam int SW_LAT = OFF + SET + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic [3:0] clk_ok = 4'h0;
    logic       req_ready;
    logic [3:0] clksel;
    logic [1:0] cur_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       fallback;

    int errors = 0;
    int checks = 0;

    dcs_sel_ctrl #(
        .OFF_CYCLES   (OFF),
        .SETTLE_CYCLES(SET),
        .RESET_SEL    (0),
        .FALLBACK_SEL (0)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .i_req_sel  (req_sel),
        .o_req_ready(req_ready),
        .i_clk_ok   (clk_ok),
        .o_clksel   (clksel),
        .o_cur_sel  (cur_sel),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_fallback (fallback)
    );

    always #5 clk = ~clk;

    typedef enum int {K_SWITCH, K_NOOP, K_ERR} kind_e;

    typedef struct {
        logic [3:0] ok;
        logic [1:0] sel;
        kind_e      kind;
        logic [3:0] exp_clksel;
        logic [1:0] exp_cur;
    } vec_t;

    typedef struct {
        int         got_done;
        int         got_err;
        int         lat;
        int         zeros;
        int         fb_lat;
        int         fb_cnt;
        int         busy1;
        int         bad_ready;
        int         tail;
        logic [3:0] clksel;
        logic [1:0] cur;
    } obs_t;

    obs_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t mk_exp(input kind_e kind, input logic [3:0] cs, input logic [1:0] cur);
        obs_t e;
        e = '{default: 0};
        e.got_done = (kind != K_ERR) ? 1 : 0;
        e.got_err  = (kind == K_ERR) ? 1 : 0;
        e.lat      = (kind == K_SWITCH) ? SW_LAT : 1;
        e.zeros    = (kind == K_SWITCH) ? OFF : 0;
        e.busy1    = (kind == K_SWITCH) ? 1 : 0;
        e.clksel   = cs;
        e.cur      = cur;
        return e;
    endfunction

    task automatic cmp(input string tag, input obs_t a, input obs_t e);
        check({tag, "_done"},      a.got_done,  e.got_done);
        check({tag, "_err"},       a.got_err,   e.got_err);
        check({tag, "_latency"},   a.lat,       e.lat);
        check({tag, "_gate_len"},  a.zeros,     e.zeros);
        check({tag, "_fb_lat"},    a.fb_lat,    e.fb_lat);
        check({tag, "_fb_pulses"}, a.fb_cnt,    e.fb_cnt);
        check({tag, "_busy"},      a.busy1,     e.busy1);
        check({tag, "_ready_busy"},a.bad_ready, e.bad_ready);
        check({tag, "_pulse_len"}, a.tail,      e.tail);
        check({tag, "_clksel"},    a.clksel,    e.clksel);
        check({tag, "_cur_sel"},   a.cur,       e.cur);
    endtask

    // Waits from the accept edge (or any start point) until done/err, recording what was seen.
    task automatic observe(output obs_t o);
        bit stop;
        o = '{default: 0};
        stop = 1'b0;
        for (int k = 1; k <= 200 && !stop; k++) begin
            @(negedge clk);
            if (k == 1) o.busy1 = busy;
            if (clksel == 4'b0000) o.zeros++;
            if (fallback) begin
                o.fb_cnt++;
                if (o.fb_lat == 0) o.fb_lat = k;
            end
            if (busy && req_ready) o.bad_ready++;
            if (done || err) begin
                o.got_done = done;
                o.got_err  = err;
                o.lat      = k;
                o.clksel   = clksel;
                o.cur      = cur_sel;
                stop       = 1'b1;
            end
        end
        @(negedge clk);
        o.tail = done || err || fallback;
    endtask

    task automatic do_request(input logic [1:0] sel, output bit accepted);
        int t;
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = sel;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_wait", req_ready, 1'b1);
            req_valid = 1'b0;
            accepted  = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            accepted = 1'b1;
        end
    endtask

    task automatic switch_to(input logic [1:0] sel);
        bit acc;
        obs_t o;
        do_request(sel, acc);
        if (acc) begin
            observe(o);
            check("setup_clksel", o.clksel, 4'b0001 << sel);
        end
    endtask

    // clksel is all-zero only while busy, and otherwise always onehot(cur_sel).
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] oh;
            oh = 4'b0001 << cur_sel;
            check("clksel_legal", ((clksel == 4'b0000) && busy) || (clksel == oh), 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    vec_t vecs[9];

    initial begin
        obs_t o;
        obs_t e;
        bit   acc;
        int   n;

        vecs[0] = '{4'hF,    2'd2, K_SWITCH, 4'b0100, 2'd2};
        vecs[1] = '{4'hF,    2'd2, K_NOOP,   4'b0100, 2'd2};
        vecs[2] = '{4'hF,    2'd0, K_SWITCH, 4'b0001, 2'd0};
        vecs[3] = '{4'b1011, 2'd2, K_ERR,    4'b0001, 2'd0};
        vecs[4] = '{4'b1011, 2'd0, K_NOOP,   4'b0001, 2'd0};
        vecs[5] = '{4'hF,    2'd3, K_SWITCH, 4'b1000, 2'd3};
        vecs[6] = '{4'hF,    2'd1, K_SWITCH, 4'b0010, 2'd1};
        vecs[7] = '{4'b0011, 2'd3, K_ERR,    4'b0010, 2'd1};
        vecs[8] = '{4'hF,    2'd0, K_SWITCH, 4'b0001, 2'd0};

        // Reset values
        clk_ok = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_clksel",   clksel,   4'b0001);
        check("rst_cur_sel",  cur_sel,  2'd0);
        check("rst_busy",     busy,     1'b0);
        check("rst_pulses",   {done, err, fallback}, 3'b000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_clksel_rel", clksel, 4'b0001);

        // Table of requests
        foreach (vecs[i]) begin
            clk_ok = vecs[i].ok;
            repeat (3) @(negedge clk);
            sb.push_back(mk_exp(vecs[i].kind, vecs[i].exp_clksel, vecs[i].exp_cur));
            do_request(vecs[i].sel, acc);
            if (acc) begin
                observe(o);
                e = sb.pop_front();
                cmp($sformatf("vec%0d", i), o, e);
            end else begin
                void'(sb.pop_front());
            end
        end

        // Fallback from source 3 when its health drops
        clk_ok = 4'hF;
        switch_to(2'd3);
        @(negedge clk);
        clk_ok = 4'b0111;
        e = mk_exp(K_SWITCH, 4'b0001, 2'd0);
        e.lat    = 3 + OFF + SET;
        e.fb_lat = 3;
        e.fb_cnt = 1;
        e.busy1  = 0;
        sb.push_back(e);
        observe(o);
        cmp("fallback", o, sb.pop_front());

        // Fallback beats a simultaneous request; the held request waits until done
        clk_ok = 4'hF;
        repeat (3) @(negedge clk);
        switch_to(2'd2);
        @(negedge clk);
        clk_ok = 4'b1011;
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 2'd1;
        check("fb_blocks_ready", req_ready, 1'b0);
        e = mk_exp(K_SWITCH, 4'b0001, 2'd0);
        e.lat    = 1 + OFF + SET;
        e.fb_lat = 1;
        e.fb_cnt = 1;
        sb.push_back(e);
        observe(o);
        cmp("fb_vs_req", o, sb.pop_front());
        req_valid = 1'b0;
        e = mk_exp(K_SWITCH, 4'b0010, 2'd1);
        e.lat   = OFF + SET;
        e.zeros = OFF - 1;
        sb.push_back(e);
        observe(o);
        cmp("held_req", o, sb.pop_front());

        // Fallback source also unhealthy: fall back once, then stay put
        @(negedge clk);
        clk_ok = 4'b0000;
        e = mk_exp(K_SWITCH, 4'b0001, 2'd0);
        e.lat    = 3 + OFF + SET;
        e.fb_lat = 3;
        e.fb_cnt = 1;
        e.busy1  = 0;
        sb.push_back(e);
        observe(o);
        cmp("fb_dead", o, sb.pop_front());
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || fallback) n++;
        end
        check("fb_no_retry", n, 0);

        // Reset asserted inside the gate window
        clk_ok = 4'hF;
        repeat (3) @(negedge clk);
        do_request(2'd2, acc);
        repeat (3) @(negedge clk);
        check("pre_rst_gated", clksel, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        check("rst_off_clksel",  clksel,  4'b0001);
        check("rst_off_cur_sel", cur_sel, 2'd0);
        check("rst_off_busy",    busy,    1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        check("rst_off_no_done", n, 0);
        check("rst_off_final", clksel, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
